// File: rtl/buf_cache_pkg.sv
// rtl/buf_cache_pkg.sv - shared types and sizes for the buffer-pool tag cache
package buf_cache_pkg;

  localparam int NUM_BUF   = 4;
  localparam int BUF_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    VICT_REQ,
    VICT_WAIT
  } state_e;

endpackage

// File: rtl/buf_tag_match.sv
// rtl/buf_tag_match.sv - 4-way tag compare with hit and lowest-free encoders
module buf_tag_match
  import buf_cache_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic [NUM_BUF-1:0]            valid,
  input  logic [NUM_BUF-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]              tag,
  output logic                          hit,
  output logic [BUF_IDX_W-1:0]          hit_idx,
  output logic                          any_free,
  output logic [BUF_IDX_W-1:0]          free_idx
);

  // Scan from the top down so the lowest matching/free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if (valid[i] && (tags[i] == tag)) begin
        hit     = 1'b1;
        hit_idx = BUF_IDX_W'(i);
      end
      if (!valid[i]) begin
        any_free = 1'b1;
        free_idx = BUF_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/buf_cache_ctrl.sv
// rtl/buf_cache_ctrl.sv - four-entry fully associative tag lookup, LFU policy requester
module buf_cache_ctrl
  import buf_cache_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic [TAG_W-1:0]     req_tag,
  output logic                 req_ready,
  input  logic                 flush,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [BUF_IDX_W-1:0] resp_buf,
  output logic                 ref_valid,
  output logic [BUF_IDX_W-1:0] ref_buf_numbr,
  output logic                 new_buf_req,
  input  logic [BUF_IDX_W-1:0] buf_num_replc
);

  state_e                        state_q, state_d;
  logic [NUM_BUF-1:0]            valid_q;
  logic [NUM_BUF-1:0][TAG_W-1:0] tags_q;
  logic [TAG_W-1:0]              tag_q;

  logic                 hit, any_free;
  logic [BUF_IDX_W-1:0] hit_idx, free_idx;

  logic                 cap_tag, clr_valid, wr_en;
  logic [BUF_IDX_W-1:0] wr_idx;
  logic                 resp_valid_d, resp_hit_d, new_buf_req_d;
  logic [BUF_IDX_W-1:0] resp_buf_d;

  buf_tag_match #(.TAG_W(TAG_W)) u_match (
    .valid    (valid_q),
    .tags     (tags_q),
    .tag      (tag_q),
    .hit      (hit),
    .hit_idx  (hit_idx),
    .any_free (any_free),
    .free_idx (free_idx)
  );

  assign req_ready = (state_q == IDLE) && !flush;

  always_comb begin
    state_d       = state_q;
    cap_tag       = 1'b0;
    clr_valid     = 1'b0;
    wr_en         = 1'b0;
    wr_idx        = '0;
    resp_valid_d  = 1'b0;
    resp_hit_d    = resp_hit;
    resp_buf_d    = resp_buf;
    new_buf_req_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          clr_valid = 1'b1;
        end else if (req_valid) begin
          cap_tag = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b1;
          resp_buf_d   = hit_idx;
          state_d      = IDLE;
        end else if (any_free) begin
          wr_en        = 1'b1;
          wr_idx       = free_idx;
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b0;
          resp_buf_d   = free_idx;
          state_d      = IDLE;
        end else begin
          new_buf_req_d = 1'b1;
          state_d       = VICT_REQ;
        end
      end
      VICT_REQ: begin
        state_d = VICT_WAIT;
      end
      VICT_WAIT: begin
        wr_en        = 1'b1;
        wr_idx       = buf_num_replc;
        resp_valid_d = 1'b1;
        resp_hit_d   = 1'b0;
        resp_buf_d   = buf_num_replc;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The policy reference index always mirrors the response index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_buf      <= '0;
      ref_valid     <= 1'b0;
      ref_buf_numbr <= '0;
      new_buf_req   <= 1'b0;
    end else begin
      state_q       <= state_d;
      resp_valid    <= resp_valid_d;
      resp_hit      <= resp_hit_d;
      resp_buf      <= resp_buf_d;
      ref_valid     <= resp_valid_d;
      ref_buf_numbr <= resp_buf_d;
      new_buf_req   <= new_buf_req_d;
      if (clr_valid) begin
        valid_q <= '0;
      end else if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap_tag) begin
      tag_q <= req_tag;
    end
    if (wr_en) begin
      tags_q[wr_idx] <= tag_q;
    end
  end

endmodule
